reg_access_sequencer: RTL
=========================

// Module: reg_access_sequencer
// PURPOSE
//   Two-requester controller for one register_32bit instance. Arbitrates round-robin between requester 0 and requester 1.
//   Drives the register's E/FunSel/In port and returns completion plus readback.
//   Adds multi-cycle PACK (byte-serial load via FunSel 110), READ (no write) and illegal-op reporting on top of the register's native ops.
// PARAMETERS
//   DATA_W      32  register/data width; only 32 is supported
//   PACK_BYTES  4   shift cycles for PACK; legal range 1..4
// PORTS
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   req0_valid   in   1       requester 0 has a command
//   req0_op      in   4       requester 0 opcode
//   req0_data    in   32      requester 0 operand
//   req0_ready   out  1       requester 0 command accepted this cycle
//   req1_valid   in   1       requester 1 has a command
//   req1_op      in   4       requester 1 opcode
//   req1_data    in   32      requester 1 operand
//   req1_ready   out  1       requester 1 command accepted this cycle
//   reg_E        out  1       register enable
//   reg_FunSel   out  3       register function select
//   reg_In       out  32      register data input
//   reg_Out      in   32      register current value
//   done         out  1       one-cycle completion pulse
//   done_id      out  1       requester that owns the completing command
//   err          out  1       completing command was an illegal op (valid with done)
//   rd_data      out  32      reg_Out while done=1, else 0
// BEHAVIOUR
//   Opcodes:
//   - 0xxx: native op; FunSel = op[2:0], In = data, 1 EXEC cycle.
//   - 1000: PACK.
//   - 1001: READ; E=0 for 1 EXEC cycle.
//   - 1010..1111: illegal.
//   FSM states: IDLE, EXEC, RESP.
//   - IDLE: grant logic is combinational and recomputed every cycle.
//     - One requester valid: that requester is granted.
//     - Both valid: the requester not granted last time wins.
//     - Handshake: the granted requester sees readyN=1 in IDLE only. On that edge, op/data/id are latched and last_grant is updated.
//     - Legal op: go to EXEC. Illegal op: go directly to RESP with err=1; reg_E is never asserted.
//   - EXEC, native op: reg_E=1, FunSel=op, In=data for exactly 1 cycle, then RESP.
//   - EXEC, PACK: PACK_BYTES cycles, byte counter k = 0..PACK_BYTES-1.
//     - Each cycle: reg_E=1, FunSel=110, In = {24'h0, data[8*(PACK_BYTES-1-k)+:8]}.
//     - Bytes are issued most significant first. After the last byte, go to RESP.
//   - EXEC, READ: reg_E=0 for 1 cycle, then RESP.
//   - RESP: 1 cycle, then IDLE.
//     - done=1, done_id = latched id, err as decided.
//     - rd_data = reg_Out, which is the post-op value.
//   Latency from the accept edge: native/READ gives done in the 2nd cycle; PACK in cycle PACK_BYTES+1; illegal in the 1st.
//   Throughput: the next accept is possible in the cycle after RESP (native ops: 1 per 3 cycles).
//   Outside EXEC: reg_E=0, reg_FunSel=000, reg_In=0.
//   Inputs are ignored outside IDLE; readyN stays 0. Dropping valid before accept is legal and leaves no sticky grant.
//   Reset (asynchronous, any state):
//   - State=IDLE, byte counter=0, last_grant=1 (so req0 wins the first tie).
//   - All outputs go to 0 immediately.
//   - An in-flight command is abandoned with no done. Register contents are left as-is.
//   Wrap-around in INC/DEC is the register's concern; the sequencer passes ops through unchanged.
// TESTING (sequencer wired to a real register_32bit)
//   1. req0 op=0010 data=A5A5A5A5
//      -> ready0 1 cycle; next cycle E=1 FunSel=010 In=A5A5A5A5
//      -> then done=1 done_id=0 err=0 rd_data=A5A5A5A5.
//   2. Both valid, op=0001 held for 6 accepts from Out=0
//      -> grants 0,1,0,1,0,1
//      -> done_id alternates; final rd_data=00000006.
//   3. Clear (0011), then PACK data=12345678
//      -> 4 EXEC cycles FunSel=110 with In[7:0]=12,34,56,78
//      -> done rd_data=12345678.
//   4. req1 op=1100 -> done on the cycle after accept with err=1, done_id=1; reg_E never 1; Out unchanged.
//   5. Reset pulsed during the 2nd PACK byte
//      -> reg_E=0 asynchronously; no done; FSM in IDLE
//      -> the next simultaneous request grants req0.
//   6. READ (1001) with Out=DEADBEEF -> reg_E stays 0; done with rd_data=DEADBEEF; rd_data=0 the cycle after.

Source files
------------

// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: round-robin two-requester front end for a single register_32bit.
// Native ops pass through unchanged; PACK, READ and illegal-op reporting are layered on top.
`default_nettype none

module reg_access_sequencer #(
  parameter int DATA_W     = 32,
  parameter int PACK_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_E,
  output logic [2:0]        reg_FunSel,
  output logic [DATA_W-1:0] reg_In,
  input  logic [DATA_W-1:0] reg_Out,
  output logic              done,
  output logic              done_id,
  output logic              err,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_PACK   = 4'b1000;
  localparam logic [3:0] OP_READ   = 4'b1001;
  localparam logic [2:0] FS_SHIFT8 = 3'b110;
  localparam logic [1:0] LAST_K    = 2'(PACK_BYTES - 1);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_id;
  logic              r_is_pack;
  logic [1:0]        r_k;
  logic [DATA_W-1:0] r_data;

  logic              w_any_valid;
  logic              w_gnt_id;
  logic              w_accept;
  logic [3:0]        w_sel_op;
  logic [DATA_W-1:0] w_sel_data;

  // Byte idx of a PACK operand, counted from the most significant packed byte.
  function automatic logic [DATA_W-1:0] pack_byte(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] idx);
    logic [7:0] b;
    b = d[8*(PACK_BYTES-1-int'(idx)) +: 8];
    return {{(DATA_W-8){1'b0}}, b};
  endfunction

  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_gnt_id    = 1'b0;
    if (req0_valid && req1_valid) w_gnt_id = ~r_last_grant;
    else if (req1_valid)          w_gnt_id = 1'b1;
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign w_accept   = (r_state == IDLE) && w_any_valid && !reset;
  assign req0_ready = w_accept && !w_gnt_id;
  assign req1_ready = w_accept &&  w_gnt_id;
  assign w_sel_op   = w_gnt_id ? req1_op   : req0_op;
  assign w_sel_data = w_gnt_id ? req1_data : req0_data;
  assign rd_data    = done ? reg_Out : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_is_pack    <= 1'b0;
      r_k          <= 2'd0;
      r_data       <= '0;
      reg_E        <= 1'b0;
      reg_FunSel   <= 3'b000;
      reg_In       <= '0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      err          <= 1'b0;
    end else begin
      reg_E      <= 1'b0;
      reg_FunSel <= 3'b000;
      reg_In     <= '0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_gnt_id;
            r_id         <= w_gnt_id;
            r_data       <= w_sel_data;
            r_is_pack    <= (w_sel_op == OP_PACK);
            r_k          <= 2'd0;
            if (!w_sel_op[3]) begin
              r_state    <= EXEC;
              reg_E      <= 1'b1;
              reg_FunSel <= w_sel_op[2:0];
              reg_In     <= w_sel_data;
            end else if (w_sel_op == OP_PACK) begin
              r_state    <= EXEC;
              reg_E      <= 1'b1;
              reg_FunSel <= FS_SHIFT8;
              reg_In     <= pack_byte(w_sel_data, 2'd0);
            end else if (w_sel_op == OP_READ) begin
              r_state <= EXEC;
            end else begin
              r_state <= RESP;
              done    <= 1'b1;
              done_id <= w_gnt_id;
              err     <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (r_is_pack && (r_k != LAST_K)) begin
            r_k        <= r_k + 2'd1;
            reg_E      <= 1'b1;
            reg_FunSel <= FS_SHIFT8;
            reg_In     <= pack_byte(r_data, r_k + 2'd1);
          end else begin
            r_state <= RESP;
            done    <= 1'b1;
            done_id <= r_id;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
